// File: rtl/riscv_top_small.sv
// riscv_top_small: compact multi-cycle RV32I core with a unified
// instruction/data memory held in an inferred block RAM.
//
// Ports:
//   clk          - single clock; all state changes on its rising edge
//   rst_n        - synchronous reset, ACTIVE HIGH despite the suffix
//   dmem_valid_o - high for the one cycle a load/store accesses memory
//
// Each instruction walks FETCH -> EXEC [-> MEM [-> LOAD_WB]]:
//   2 cycles for ALU/branch/jump/NOP, 3 for stores, 4 for loads.
// Addresses wrap modulo MEM_SIZE; misaligned accesses silently drop low bits.
module riscv_top_small #(
  parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000,
  parameter int          MEM_SIZE     = 4096,
  parameter string       INIT_FILE    = "firmware.hex"
) (
  input  logic clk,
  input  logic rst_n,
  output logic dmem_valid_o
);

  localparam int AW    = $clog2(MEM_SIZE);
  localparam int WORDS = MEM_SIZE / 4;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_LOAD_WB} state_t;

  state_t state_reg, state_next;

  // Unified memory, registered read port
  logic [31:0]   mem [0:WORDS-1];
  logic [31:0]   rdata_reg;
  logic [AW-3:0] mem_addr;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;

  // Architectural and inter-state registers
  logic [31:0]   regs [0:31];
  logic [31:0]   pc_reg, pc_next, pc_plus4;
  logic [AW-1:0] addr_reg;
  logic [31:0]   addr_next;
  logic [31:0]   sdata_reg;
  logic [2:0]    ls_funct3_reg;
  logic [4:0]    ls_rd_reg;
  logic          is_store_reg;

  // Decode: in EXEC the fetched instruction sits in the RAM output register
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val;

  assign instr    = rdata_reg;
  assign opcode   = instr[6:0];
  assign rd       = instr[11:7];
  assign funct3   = instr[14:12];
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];
  assign funct7_5 = instr[30];
  assign imm_i    = {{20{instr[31]}}, instr[31:20]};
  assign imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u    = {instr[31:12], 12'b0};
  assign imm_j    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
  assign pc_plus4 = pc_reg + 32'd4;

  // ALU shared by OP and OP-IMM
  logic [31:0] alu_b, alu_y;
  logic [4:0]  shamt;
  always_comb begin
    alu_b = (opcode == OPC_OP) ? rs2_val : imm_i;
    shamt = alu_b[4:0];
    unique case (funct3)
      3'b000:  alu_y = (opcode == OPC_OP && funct7_5) ? rs1_val - alu_b : rs1_val + alu_b;
      3'b001:  alu_y = rs1_val << shamt;
      3'b010:  alu_y = {31'b0, $signed(rs1_val) < $signed(alu_b)};
      3'b011:  alu_y = {31'b0, rs1_val < alu_b};
      3'b100:  alu_y = rs1_val ^ alu_b;
      // instr[30] selects SRA/SRAI for both formats
      3'b101:  alu_y = funct7_5 ? 32'($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
      3'b110:  alu_y = rs1_val | alu_b;
      default: alu_y = rs1_val & alu_b;
    endcase
  end

  logic br_taken;
  always_comb begin
    case (funct3)
      3'b000:  br_taken = (rs1_val == rs2_val);
      3'b001:  br_taken = (rs1_val != rs2_val);
      3'b100:  br_taken = ($signed(rs1_val) < $signed(rs2_val));
      3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  br_taken = (rs1_val < rs2_val);
      3'b111:  br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  // Load extraction from the word returned in LOAD_WB
  logic [31:0] lane_word, load_val;
  logic [15:0] load_half;
  always_comb begin
    lane_word = rdata_reg >> {addr_reg[1:0], 3'b000};
    load_half = addr_reg[1] ? rdata_reg[31:16] : rdata_reg[15:0];
    case (ls_funct3_reg)
      3'b000:  load_val = {{24{lane_word[7]}}, lane_word[7:0]};
      3'b001:  load_val = {{16{load_half[15]}}, load_half};
      3'b100:  load_val = {24'b0, lane_word[7:0]};
      3'b101:  load_val = {16'b0, load_half};
      default: load_val = rdata_reg;
    endcase
  end

  // Datapath: register writeback, next PC and effective address
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  always_comb begin
    rf_we     = 1'b0;
    rf_waddr  = rd;
    rf_wdata  = alu_y;
    pc_next   = pc_reg;
    addr_next = (opcode == OPC_STORE) ? rs1_val + imm_s : rs1_val + imm_i;
    case (state_reg)
      S_EXEC: begin
        case (opcode)
          OPC_LUI:   begin rf_we = 1'b1; rf_wdata = imm_u;          pc_next = pc_plus4; end
          OPC_AUIPC: begin rf_we = 1'b1; rf_wdata = pc_reg + imm_u; pc_next = pc_plus4; end
          // Link value comes from pc_reg and the target from the old rs1,
          // so rd == rs1 behaves correctly.
          OPC_JAL:   begin rf_we = 1'b1; rf_wdata = pc_plus4; pc_next = pc_reg + imm_j; end
          OPC_JALR:  begin rf_we = 1'b1; rf_wdata = pc_plus4; pc_next = (rs1_val + imm_i) & ~32'd1; end
          OPC_BRANCH: pc_next = br_taken ? pc_reg + imm_b : pc_plus4;
          OPC_OPIMM, OPC_OP: begin rf_we = 1'b1; pc_next = pc_plus4; end
          OPC_LOAD, OPC_STORE: pc_next = pc_reg;
          default:   pc_next = pc_plus4;
        endcase
      end
      S_MEM:     if (is_store_reg) pc_next = pc_plus4;
      S_LOAD_WB: begin
        rf_we    = 1'b1;
        rf_waddr = ls_rd_reg;
        rf_wdata = load_val;
        pc_next  = pc_plus4;
      end
      default: ;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_reg <= S_FETCH;
      pc_reg    <= BOOT_ADDRESS;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      if (state_reg == S_EXEC) begin
        addr_reg      <= addr_next[AW-1:0];
        sdata_reg     <= rs2_val;
        ls_funct3_reg <= funct3;
        ls_rd_reg     <= rd;
        is_store_reg  <= (opcode == OPC_STORE);
      end
    end
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH:   state_next = S_EXEC;
      S_EXEC:    state_next = (opcode == OPC_LOAD || opcode == OPC_STORE) ? S_MEM : S_FETCH;
      S_MEM:     state_next = is_store_reg ? S_FETCH : S_LOAD_WB;
      default:   state_next = S_FETCH;
    endcase
  end

  // FSM: outputs. Reset gates the access so a store caught in MEM is dropped.
  always_comb begin
    dmem_valid_o = (state_reg == S_MEM) && !rst_n;
    mem_we       = dmem_valid_o && is_store_reg;
    mem_addr     = (state_reg == S_MEM) ? addr_reg[AW-1:2] : pc_reg[AW-1:2];
    case (ls_funct3_reg[1:0])
      2'b00: begin
        mem_be    = 4'b0001 << addr_reg[1:0];
        mem_wdata = {4{sdata_reg[7:0]}};
      end
      2'b01: begin
        mem_be    = addr_reg[1] ? 4'b1100 : 4'b0011;
        mem_wdata = {2{sdata_reg[15:0]}};
      end
      default: begin
        mem_be    = 4'b1111;
        mem_wdata = sdata_reg;
      end
    endcase
  end

  // Block RAM port
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
    rdata_reg <= mem[mem_addr];
  end

  // Register file; x0 never written
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (rf_we && rf_waddr != 5'd0) begin
      regs[rf_waddr] <= rf_wdata;
    end
  end

  // Address bits above the memory size are ignored by design
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_next[31:AW];

endmodule

// File: tb/tb_riscv_top_small.sv
module tb_riscv_top_small;

  localparam int WORDS = 1024;

  logic clk;
  logic rst_n;
  logic dmem_valid_o;

  int errors = 0;
  int checks = 0;

  logic [31:0] prog [$];

  riscv_top_small #(
    .BOOT_ADDRESS(32'h0000_0000),
    .MEM_SIZE(4096),
    .INIT_FILE("")
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .dmem_valid_o(dmem_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Holds reset, loads prog into memory, releases reset just after an edge
  // so that the current cycle is the first FETCH.
  task automatic load_and_start();
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < WORDS; i++) dut.mem[i] <= 32'h0;
    for (int i = 0; i < prog.size(); i++) dut.mem[i] <= prog[i];
    @(posedge clk); #1;
    rst_n = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    step(3);
    checks++; if (dut.pc_reg !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", dut.pc_reg, 32'h0); end
    checks++; if (dut.state_reg !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dut.state_reg); end
    checks++; if (dmem_valid_o !== 1'b0) begin errors++; $display("FAIL reset_dmem_valid: got %b want 0", dmem_valid_o); end
    checks++; if (dut.regs[1] !== 32'h0) begin errors++; $display("FAIL reset_x1: got %h want 0", dut.regs[1]); end
    $display("test_reset done");
  endtask

  task automatic test_nop();
    logic [31:0] exp_pc;
    prog = '{};
    load_and_start();
    for (int k = 1; k <= 20; k++) begin
      checks++; if (dmem_valid_o !== 1'b0) begin errors++; $display("FAIL nop_dmem_valid cycle %0d: got %b want 0", k, dmem_valid_o); end
      step(1);
      exp_pc = 32'(4 * (k / 2));
      checks++; if (dut.pc_reg !== exp_pc) begin errors++; $display("FAIL nop_pc after %0d cycles: got %h want %h", k, dut.pc_reg, exp_pc); end
    end
    $display("test_nop done");
  endtask

  task automatic test_alu();
    prog = '{32'h00500093, 32'hFF908113, 32'h402081B3, 32'h40115313,
             32'h01C15393, 32'h00112433, 32'h001134B3, 32'h00109533,
             32'h123455B7, 32'h00001617, 32'h00100013};
    load_and_start();
    step(4);
    checks++; if (dut.regs[3] !== 32'h0) begin errors++; $display("FAIL alu_x3_early: got %h want 0", dut.regs[3]); end
    step(2);
    checks++; if (dut.regs[1] !== 32'h5) begin errors++; $display("FAIL alu_x1: got %h want 5", dut.regs[1]); end
    checks++; if (dut.regs[2] !== 32'hFFFFFFFE) begin errors++; $display("FAIL alu_x2: got %h want fffffffe", dut.regs[2]); end
    checks++; if (dut.regs[3] !== 32'h7) begin errors++; $display("FAIL alu_x3: got %h want 7", dut.regs[3]); end
    checks++; if (dut.pc_reg !== 32'hC) begin errors++; $display("FAIL alu_pc6: got %h want c", dut.pc_reg); end
    step(16);
    checks++; if (dut.regs[6] !== 32'hFFFFFFFF) begin errors++; $display("FAIL alu_srai: got %h want ffffffff", dut.regs[6]); end
    checks++; if (dut.regs[7] !== 32'h0000000F) begin errors++; $display("FAIL alu_srli: got %h want f", dut.regs[7]); end
    checks++; if (dut.regs[8] !== 32'h1) begin errors++; $display("FAIL alu_slt: got %h want 1", dut.regs[8]); end
    checks++; if (dut.regs[9] !== 32'h0) begin errors++; $display("FAIL alu_sltu: got %h want 0", dut.regs[9]); end
    checks++; if (dut.regs[10] !== 32'hA0) begin errors++; $display("FAIL alu_sll: got %h want a0", dut.regs[10]); end
    checks++; if (dut.regs[11] !== 32'h12345000) begin errors++; $display("FAIL alu_lui: got %h want 12345000", dut.regs[11]); end
    checks++; if (dut.regs[12] !== 32'h00001024) begin errors++; $display("FAIL alu_auipc: got %h want 1024", dut.regs[12]); end
    checks++; if (dut.regs[0] !== 32'h0) begin errors++; $display("FAIL alu_x0: got %h want 0", dut.regs[0]); end
    checks++; if (dut.pc_reg !== 32'h2C) begin errors++; $display("FAIL alu_pc22: got %h want 2c", dut.pc_reg); end
    $display("test_alu done");
  endtask

  task automatic test_load_store();
    logic exp_v;
    prog = '{32'h80FF01B7, 32'h08118193, 32'h10302023, 32'h10000203,
             32'h10304283, 32'h00001337, 32'h00332223, 32'h103006A3,
             32'h10201683};
    load_and_start();
    for (int k = 1; k <= 27; k++) begin
      exp_v = (k == 7 || k == 10 || k == 14 || k == 20 || k == 23 || k == 26);
      checks++; if (dmem_valid_o !== exp_v) begin errors++; $display("FAIL ls_dmem_valid cycle %0d: got %b want %b", k, dmem_valid_o, exp_v); end
      step(1);
    end
    checks++; if (dut.mem[64] !== 32'h80FF0081) begin errors++; $display("FAIL ls_sw_word: got %h want 80ff0081", dut.mem[64]); end
    checks++; if (dut.regs[4] !== 32'hFFFFFF81) begin errors++; $display("FAIL ls_lb: got %h want ffffff81", dut.regs[4]); end
    checks++; if (dut.regs[5] !== 32'h00000080) begin errors++; $display("FAIL ls_lbu: got %h want 80", dut.regs[5]); end
    checks++; if (dut.mem[1] !== 32'h80FF0081) begin errors++; $display("FAIL ls_wrap_store: got %h want 80ff0081", dut.mem[1]); end
    checks++; if (dut.mem[67] !== 32'h00008100) begin errors++; $display("FAIL ls_sb_lane: got %h want 00008100", dut.mem[67]); end
    checks++; if (dut.regs[13] !== 32'hFFFF80FF) begin errors++; $display("FAIL ls_lh_upper: got %h want ffff80ff", dut.regs[13]); end
    checks++; if (dut.pc_reg !== 32'h24) begin errors++; $display("FAIL ls_pc: got %h want 24", dut.pc_reg); end
    $display("test_load_store done");
  endtask

  task automatic test_branch_jump();
    prog = '{32'h00300093, 32'h00108463, 32'h00100113, 32'h00109463,
             32'h00900193, 32'h0, 32'h0, 32'h0,
             32'h010000EF, 32'h00200113, 32'h0, 32'h0,
             32'h005080E7};
    load_and_start();
    step(4);
    checks++; if (dut.pc_reg !== 32'hC) begin errors++; $display("FAIL br_beq_taken: got %h want c", dut.pc_reg); end
    step(2);
    checks++; if (dut.pc_reg !== 32'h10) begin errors++; $display("FAIL br_bne_not_taken: got %h want 10", dut.pc_reg); end
    step(10);
    checks++; if (dut.pc_reg !== 32'h30) begin errors++; $display("FAIL br_jal_pc: got %h want 30", dut.pc_reg); end
    checks++; if (dut.regs[1] !== 32'h24) begin errors++; $display("FAIL br_jal_link: got %h want 24", dut.regs[1]); end
    checks++; if (dut.regs[2] !== 32'h0) begin errors++; $display("FAIL br_skipped: got %h want 0", dut.regs[2]); end
    checks++; if (dut.regs[3] !== 32'h9) begin errors++; $display("FAIL br_fallthrough: got %h want 9", dut.regs[3]); end
    step(2);
    checks++; if (dut.pc_reg !== 32'h28) begin errors++; $display("FAIL br_jalr_pc: got %h want 28", dut.pc_reg); end
    checks++; if (dut.regs[1] !== 32'h34) begin errors++; $display("FAIL br_jalr_link: got %h want 34", dut.regs[1]); end
    $display("test_branch_jump done");
  endtask

  task automatic test_mid_reset();
    prog = '{32'h00500093, 32'h08102023};
    load_and_start();
    step(4);
    checks++; if (dut.state_reg !== 2'd2) begin errors++; $display("FAIL mr_in_mem: got %0d want 2", dut.state_reg); end
    checks++; if (dmem_valid_o !== 1'b1) begin errors++; $display("FAIL mr_valid_before: got %b want 1", dmem_valid_o); end
    checks++; if (dut.regs[1] !== 32'h5) begin errors++; $display("FAIL mr_x1_before: got %h want 5", dut.regs[1]); end
    rst_n = 1'b1;
    #1;
    checks++; if (dmem_valid_o !== 1'b0) begin errors++; $display("FAIL mr_valid_in_reset: got %b want 0", dmem_valid_o); end
    step(1);
    checks++; if (dut.mem[32] !== 32'h0) begin errors++; $display("FAIL mr_no_store: got %h want 0", dut.mem[32]); end
    checks++; if (dut.pc_reg !== 32'h0) begin errors++; $display("FAIL mr_pc: got %h want 0", dut.pc_reg); end
    checks++; if (dut.regs[1] !== 32'h0) begin errors++; $display("FAIL mr_x1_cleared: got %h want 0", dut.regs[1]); end
    checks++; if (dut.state_reg !== 2'd0) begin errors++; $display("FAIL mr_state: got %0d want 0", dut.state_reg); end
    checks++; if (dut.mem[1] !== 32'h08102023) begin errors++; $display("FAIL mr_mem_kept: got %h want 08102023", dut.mem[1]); end
    $display("test_mid_reset done");
  endtask

  initial begin
    rst_n = 1'b1;
    test_reset();
    test_nop();
    test_alu();
    test_load_store();
    test_branch_jump();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
